// File: rtl/instmem_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the arbiter and the instruction memory.
// The arbiter takes the slave modport; the requester/memory side takes the master modport.
interface instmem_arbiter_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  fetch_req;
    logic [WORD_WIDTH-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_rvalid;
    logic [WORD_WIDTH-1:0] fetch_rdata;
    logic                  fetch_err;

    logic                  dbg_req;
    logic [WORD_WIDTH-1:0] dbg_addr;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [WORD_WIDTH-1:0] dbg_rdata;
    logic                  dbg_err;

    logic [WORD_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
    );

    modport master (
        output fetch_req, fetch_addr, dbg_req, dbg_addr, mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
    );
endinterface

// File: rtl/instmem_arbiter.sv
// Round-robin arbiter sharing one instruction memory port between CPU fetch and debug/loader.
// Combinational grant, single-cycle response; bad addresses are answered with err and rdata 0.
module instmem_arbiter #(
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned WORD_WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    instmem_arbiter_if.slave   bus
);
    typedef enum logic {ReqFetch = 1'b0, ReqDbg = 1'b1} req_id_e;

    localparam logic [WORD_WIDTH-1:0] MaxAddr = WORD_WIDTH'(MEM_DEPTH - 4);

    req_id_e               rr_q, rr_d;
    logic                  pend_q;
    req_id_e               resp_id_q;
    logic                  err_q;
    logic [WORD_WIDTH-1:0] held_addr_q;

    logic                  any_gnt;
    logic [WORD_WIDTH-1:0] gnt_addr;
    logic                  gnt_err;
    logic                  resp_valid;

    always_comb begin
        bus.fetch_gnt = 1'b0;
        bus.dbg_gnt   = 1'b0;
        rr_d          = rr_q;
        // Grants are gated by rst so nothing issued during reset can produce a response.
        if (!rst) begin
            if (bus.fetch_req && (!bus.dbg_req || rr_q == ReqFetch)) begin
                bus.fetch_gnt = 1'b1;
                rr_d          = ReqDbg;
            end else if (bus.dbg_req) begin
                bus.dbg_gnt = 1'b1;
                rr_d        = ReqFetch;
            end
        end
        any_gnt  = bus.fetch_gnt | bus.dbg_gnt;
        gnt_addr = bus.dbg_gnt ? bus.dbg_addr : bus.fetch_addr;
        gnt_err  = (gnt_addr[1:0] != 2'b00) || (gnt_addr > MaxAddr);
    end

    always_comb begin
        bus.mem_addr = held_addr_q;
        if (rst) begin
            bus.mem_addr = '0;
        end else if (any_gnt && !gnt_err) begin
            bus.mem_addr = gnt_addr;
        end
    end

    always_comb begin
        resp_valid       = pend_q && !rst;
        bus.fetch_rvalid = resp_valid && (resp_id_q == ReqFetch);
        bus.dbg_rvalid   = resp_valid && (resp_id_q == ReqDbg);
        bus.fetch_err    = bus.fetch_rvalid && err_q;
        bus.dbg_err      = bus.dbg_rvalid && err_q;
        bus.fetch_rdata  = (bus.fetch_rvalid && !err_q) ? bus.mem_rdata : '0;
        bus.dbg_rdata    = (bus.dbg_rvalid && !err_q) ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= ReqFetch;
            pend_q      <= 1'b0;
            resp_id_q   <= ReqFetch;
            err_q       <= 1'b0;
            held_addr_q <= '0;
        end else begin
            rr_q   <= rr_d;
            pend_q <= any_gnt;
            if (any_gnt) begin
                resp_id_q <= bus.dbg_gnt ? ReqDbg : ReqFetch;
                err_q     <= gnt_err;
            end
            // Erroring requests never disturb the address presented to memory.
            if (any_gnt && !gnt_err) begin
                held_addr_q <= gnt_addr;
            end
        end
    end
endmodule
